// File: rtl/pkg_conecta4.sv
// Shared Connecta-4 board definitions: dimensions, cell/state encodings and the
// board type consumed by both gestor_tablero and detector_victoria.
package pkg_conecta4;

    localparam int unsigned FILAS    = 6;
    localparam int unsigned COLUMNAS = 7;
    localparam int unsigned CW       = $clog2(COLUMNAS);
    localparam int unsigned FW       = 3;
    localparam int unsigned PW       = 6;
    localparam int unsigned CASILLAS = FILAS * COLUMNAS;

    typedef enum logic [1:0] {
        VACIA = 2'd0,
        J1    = 2'd1,
        J2    = 2'd2
    } celda_t;

    // Row 0 is the top row; each cell is a 2-bit celda_t code.
    typedef logic [0:FILAS-1][0:COLUMNAS-1][1:0] tablero_t;

    typedef enum logic [1:0] {
        REPOSO,
        BUSCAR,
        CAER,
        ESCRIBIR
    } estado_t;

    function automatic logic [1:0] otro_jugador(input logic [1:0] jugador);
        return (jugador == 2'(J1)) ? 2'(J2) : 2'(J1);
    endfunction

endpackage

// File: rtl/gestor_tablero.sv
// Connecta-4 board owner: accepts column drops, scans the column bottom-up, writes the piece, alternates turns.
// Define CAIDA_ANIMADA_EN to insert the tick-paced falling-piece animation before each write.
module gestor_tablero
    import pkg_conecta4::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           reiniciar,
    input  logic           soltar_valid,
    output logic           soltar_ready,
    input  logic [CW-1:0]  columna,
    input  logic           congelar,
    input  logic           tick_caida,
    output tablero_t       tablero,
    output logic [1:0]     turno,
    output logic           jugada_ok,
    output logic           jugada_invalida,
    output logic [FW-1:0]  ultima_fila,
    output logic [CW-1:0]  ultima_col,
    output logic [PW-1:0]  piezas,
    output logic           tablero_lleno,
    output logic           pieza_caida_valid,
    output logic [FW-1:0]  pieza_caida_fila
);

    estado_t        estado, estado_sig;
    logic [CW-1:0]  col_q;
    logic [FW-1:0]  fila_q;
    logic [FW-1:0]  destino_q;
    logic [1:0]     celda_actual;

    logic aceptar, invalida_sig, hallado, bajar, escribir;

    assign soltar_ready = (estado == REPOSO) && !congelar && !tablero_lleno && !reiniciar;
    assign celda_actual = tablero[fila_q][col_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= REPOSO;
        else        estado <= estado_sig;
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        estado_sig   = estado;
        aceptar      = 1'b0;
        invalida_sig = 1'b0;
        hallado      = 1'b0;
        bajar        = 1'b0;
        escribir     = 1'b0;
        unique case (estado)
            REPOSO: begin
                if (soltar_valid && soltar_ready) begin
                    if (columna >= CW'(COLUMNAS)) begin
                        invalida_sig = 1'b1;
                    end else begin
                        aceptar    = 1'b1;
                        estado_sig = BUSCAR;
                    end
                end
            end
            BUSCAR: begin
                if (celda_actual == VACIA) begin
                    hallado = 1'b1;
`ifdef CAIDA_ANIMADA_EN
                    estado_sig = CAER;
`else
                    estado_sig = ESCRIBIR;
`endif
                end else if (fila_q == '0) begin
                    invalida_sig = 1'b1;
                    estado_sig   = REPOSO;
                end else begin
                    bajar = 1'b1;
                end
            end
            CAER: begin
`ifdef CAIDA_ANIMADA_EN
                if (tick_caida && (pieza_caida_fila == destino_q)) estado_sig = ESCRIBIR;
`else
                estado_sig = REPOSO;
`endif
            end
            ESCRIBIR: begin
                escribir   = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
        if (reiniciar) estado_sig = REPOSO;
    end

    // Board, turn and move bookkeeping; reiniciar clears everything and drops any pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tablero         <= '0;
            turno           <= 2'(J1);
            piezas          <= '0;
            tablero_lleno   <= 1'b0;
            ultima_fila     <= '0;
            ultima_col      <= '0;
            jugada_ok       <= 1'b0;
            jugada_invalida <= 1'b0;
            col_q           <= '0;
            fila_q          <= '0;
            destino_q       <= '0;
        end else if (reiniciar) begin
            tablero         <= '0;
            turno           <= 2'(J1);
            piezas          <= '0;
            tablero_lleno   <= 1'b0;
            ultima_fila     <= '0;
            ultima_col      <= '0;
            jugada_ok       <= 1'b0;
            jugada_invalida <= 1'b0;
            col_q           <= '0;
            fila_q          <= '0;
            destino_q       <= '0;
        end else begin
            jugada_ok       <= escribir;
            jugada_invalida <= invalida_sig;
            // Only in-range columns are latched so the scan never indexes past the board.
            if (aceptar) begin
                col_q  <= columna;
                fila_q <= FW'(FILAS - 1);
            end
            if (bajar)   fila_q    <= fila_q - FW'(1);
            if (hallado) destino_q <= fila_q;
            if (escribir) begin
                tablero[destino_q][col_q] <= turno;
                turno                     <= otro_jugador(turno);
                piezas                    <= piezas + PW'(1);
                tablero_lleno             <= (piezas == PW'(CASILLAS - 1));
                ultima_fila               <= destino_q;
                ultima_col                <= col_q;
            end
        end
    end

`ifdef CAIDA_ANIMADA_EN
    // Falling-piece overlay: starts at the top row and steps down one row per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pieza_caida_valid <= 1'b0;
            pieza_caida_fila  <= '0;
        end else if (reiniciar) begin
            pieza_caida_valid <= 1'b0;
            pieza_caida_fila  <= '0;
        end else if (hallado) begin
            pieza_caida_valid <= 1'b1;
            pieza_caida_fila  <= '0;
        end else if ((estado == CAER) && tick_caida) begin
            if (pieza_caida_fila == destino_q) pieza_caida_valid <= 1'b0;
            else                               pieza_caida_fila  <= pieza_caida_fila + FW'(1);
        end
    end
`else
    logic unused_tick_caida;
    assign unused_tick_caida = tick_caida;
    assign pieza_caida_valid = 1'b0;
    assign pieza_caida_fila  = '0;
`endif

endmodule
